axil_mem_port: RTL and testbench

//   Single-outstanding AXI-Lite master bridge: turns the fetch/LSU request triple
//   (addr, rd/wr, valid) into AXI-Lite AR/R or AW/W/B transactions. Returns a
//   one-cycle done pulse with registered read data.

---
 rtl/axil_mem_port_if.sv | 41 ++++
 rtl/axil_mem_port.sv | 160 ++++++++++++++++
 tb/tb_axil_mem_port.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mem_port_if.sv
// AXI-Lite channel bundle between the memory-port master and its slave.
interface axil_interface #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport axil_master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport axil_slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_mem_port.sv
// Single-outstanding AXI-Lite master for the fetch/LSU memory port.
// One request at a time; completion is a one-cycle done pulse with registered read data.
module axil_mem_port #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [2:0]  AR_PROT    = 3'b100,
   parameter logic [2:0]  AW_PROT    = 3'b000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  valid,
   input  logic [3:0]            be,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  done,
   output logic                  err,
   output logic                  busy,
   axil_interface.axil_master    axil_bus
);
   localparam int unsigned           STRB_W    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_done;
   logic                  r_err;
   logic                  r_busy;

   logic w_aw_fire;
   logic w_w_fire;
   logic w_aw_ok;
   logic w_w_ok;

   // AW and W may complete in either order or together; each side is tracked separately.
   assign w_aw_fire = r_awvalid & axil_bus.awready;
   assign w_w_fire  = r_wvalid  & axil_bus.wready;
   assign w_aw_ok   = r_aw_done | w_aw_fire;
   assign w_w_ok    = r_w_done  | w_w_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_araddr   <= '0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_data_out <= '0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (valid && wr) begin
                  r_awaddr  <= addr & ADDR_MASK;
                  r_wdata   <= data_in;
                  r_wstrb   <= STRB_W'(be);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= WR_REQ;
               end else if (valid && rd) begin
                  r_araddr  <= addr & ADDR_MASK;
                  r_arvalid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (axil_bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axil_bus.rvalid) begin
                  r_rready   <= 1'b0;
                  r_data_out <= axil_bus.rdata;
                  r_err      <= (axil_bus.rresp != 2'b00);
                  r_done     <= 1'b1;
                  r_state    <= DONE;
               end
            end
            WR_REQ: begin
               if (w_aw_fire) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_fire) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_ok && w_w_ok) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axil_bus.bvalid) begin
                  r_bready <= 1'b0;
                  r_err    <= (axil_bus.bresp != 2'b00);
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               // Requests are deliberately ignored here so the requester can advance addr on done.
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_out = r_data_out;
   assign done     = r_done;
   assign err      = r_err;
   assign busy     = r_busy;

   assign axil_bus.awaddr  = r_awaddr;
   assign axil_bus.awprot  = AW_PROT;
   assign axil_bus.awvalid = r_awvalid;
   assign axil_bus.wdata   = r_wdata;
   assign axil_bus.wstrb   = r_wstrb;
   assign axil_bus.wvalid  = r_wvalid;
   assign axil_bus.bready  = r_bready;
   assign axil_bus.araddr  = r_araddr;
   assign axil_bus.arprot  = AR_PROT;
   assign axil_bus.arvalid = r_arvalid;
   assign axil_bus.rready  = r_rready;
endmodule

// File: tb/tb_axil_mem_port.sv
// Directed bench for axil_mem_port: behavioural AXI-Lite slave with programmable
// wait states, and a queue of expected completions checked on each done pulse.
module tb_axil_mem_port;
   typedef struct packed {
      logic [31:0] dout;
      logic        err;
   } exp_t;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic [31:0] addr    = '0;
   logic [31:0] data_in = '0;
   logic        wr      = 1'b0;
   logic        rd      = 1'b0;
   logic        valid   = 1'b0;
   logic [3:0]  be      = '0;
   logic [31:0] data_out;
   logic        done;
   logic        err;
   logic        busy;

   axil_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axil_mem_port #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .AR_PROT   (3'b100),
      .AW_PROT   (3'b000)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (addr),
      .data_in (data_in),
      .wr      (wr),
      .rd      (rd),
      .valid   (valid),
      .be      (be),
      .data_out(data_out),
      .done    (done),
      .err     (err),
      .busy    (busy),
      .axil_bus(bus)
   );

   always #5 clk = ~clk;

   // slave configuration, written by the stimulus block
   int          ar_delay      = 0;
   int          r_delay       = 0;
   int          aw_delay      = 0;
   int          w_delay       = 0;
   logic [31:0] rdata_cfg     = '0;
   logic [1:0]  rresp_cfg     = '0;
   logic [1:0]  bresp_cfg     = '0;
   bit          rdata_by_addr = 1'b0;

   // slave state and observation log
   int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_cnt = 0;
   logic        r_pend = 1'b0, s_rvalid = 1'b0, s_bvalid = 1'b0;
   logic        aw_got = 1'b0, w_got = 1'b0, ar_hold = 1'b0;
   logic [31:0] ar_hold_addr = '0, s_rdata = '0;
   logic [1:0]  s_rresp = '0, s_bresp = '0;
   logic [31:0] last_awaddr = '0, last_wdata = '0;
   logic [3:0]  last_wstrb = '0;
   logic [2:0]  last_awprot = '1;
   int          stab_err = 0, b_cnt = 0, done_cnt = 0;
   logic [31:0] ar_log[$];

   logic        aw_hs, w_hs;
   assign aw_hs = bus.awvalid && bus.awready;
   assign w_hs  = bus.wvalid && bus.wready;

   assign bus.arready = bus.arvalid && (ar_wait >= ar_delay);
   assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
   assign bus.wready  = bus.wvalid && (w_wait >= w_delay);
   assign bus.rvalid  = s_rvalid;
   assign bus.rdata   = s_rdata;
   assign bus.rresp   = s_rresp;
   assign bus.bvalid  = s_bvalid;
   assign bus.bresp   = s_bresp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_wait  <= 0;
         aw_wait  <= 0;
         w_wait   <= 0;
         r_cnt    <= 0;
         r_pend   <= 1'b0;
         s_rvalid <= 1'b0;
         s_bvalid <= 1'b0;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         ar_hold  <= 1'b0;
      end else begin
         if (ar_hold && (!bus.arvalid || bus.araddr != ar_hold_addr)) stab_err <= stab_err + 1;
         ar_hold      <= bus.arvalid && !bus.arready;
         ar_hold_addr <= bus.araddr;
         if (bus.arvalid && bus.arready) begin
            ar_log.push_back(bus.araddr);
            ar_wait <= 0;
            s_rdata <= rdata_by_addr ? {16'hC0DE, bus.araddr[15:0]} : rdata_cfg;
            s_rresp <= rresp_cfg;
            if (r_delay == 0) s_rvalid <= 1'b1;
            else begin
               r_pend <= 1'b1;
               r_cnt  <= r_delay;
            end
         end else if (bus.arvalid) ar_wait <= ar_wait + 1;
         if (r_pend) begin
            if (r_cnt <= 1) begin
               s_rvalid <= 1'b1;
               r_pend   <= 1'b0;
            end else r_cnt <= r_cnt - 1;
         end
         if (s_rvalid && bus.rready) s_rvalid <= 1'b0;
         if (aw_hs) begin
            last_awaddr <= bus.awaddr;
            last_awprot <= bus.awprot;
            aw_got      <= 1'b1;
            aw_wait     <= 0;
         end else if (bus.awvalid) aw_wait <= aw_wait + 1;
         if (w_hs) begin
            last_wdata <= bus.wdata;
            last_wstrb <= bus.wstrb;
            w_got      <= 1'b1;
            w_wait     <= 0;
         end else if (bus.wvalid) w_wait <= w_wait + 1;
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            s_bvalid <= 1'b1;
            s_bresp  <= bresp_cfg;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end
         if (s_bvalid && bus.bready) begin
            s_bvalid <= 1'b0;
            b_cnt    <= b_cnt + 1;
         end
      end
   end

   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   exp_t        sb[$];
   logic [31:0] model_dout = '0;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one request for a single accepting edge, then scramble the inputs.
   task automatic drive_req(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b);
      exp_t e;
      addr = a; data_in = d; be = b; wr = w; rd = r; valid = 1'b1;
      if (w) begin
         e.dout = model_dout;
         e.err  = (bresp_cfg != 2'b00);
      end else begin
         model_dout = rdata_by_addr ? {16'hC0DE, a[15:0] & 16'hFFFC} : rdata_cfg;
         e.dout = model_dout;
         e.err  = (rresp_cfg != 2'b00);
      end
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = '1; data_in = '1; be = '0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc, input int exp_lat);
      int   cyc;
      exp_t e;
      cyc = 1;
      while (done !== 1'b1 && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         sb.delete();
         model_dout = '0;
         @(negedge clk);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_data"}, data_out, e.dout);
      chk({tag, "_err"}, err, e.err);
      chk({tag, "_latency"}, cyc, exp_lat);
      @(negedge clk);
      chk({tag, "_pulse_end"}, {done, err, busy}, 3'b000);
   endtask

   initial begin
      int   n, dc0, bc0;
      exp_t e;

      repeat (3) @(negedge clk);
      chk("rst_outs", {done, err, busy}, 3'b000);
      chk("rst_dout", data_out, 32'h0);
      chk("rst_axi_valid", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 5'b0);
      chk("rst_axi_data", {bus.araddr, bus.awaddr}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // zero-wait read
      rdata_cfg = 32'h00100073;
      drive_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
      chk("s1_ar", {bus.arvalid, bus.araddr, bus.arprot, busy}, {1'b1, 32'h100, 3'b100, 1'b1});
      wait_done("s1", 10, 3);

      // AR and R wait states
      ar_delay = 3; r_delay = 2; rdata_cfg = 32'h11223344; dc0 = done_cnt;
      drive_req(1'b0, 1'b1, 32'h104, 32'h0, 4'h0);
      wait_done("s2", 20, 8);
      chk("s2_ar_stable", stab_err, 0);
      chk("s2_one_done", done_cnt - dc0, 1);
      ar_delay = 0; r_delay = 0;

      // write, W accepted before AW
      aw_delay = 2; w_delay = 0; bc0 = b_cnt; dc0 = done_cnt;
      drive_req(1'b1, 1'b0, 32'h203, 32'hDEADBEEF, 4'b0011);
      wait_done("s3", 20, 5);
      chk("s3_aw", {last_awaddr, last_awprot}, {32'h200, 3'b000});
      chk("s3_w", {last_wdata, last_wstrb}, {32'hDEADBEEF, 4'b0011});
      chk("s3_one_b", b_cnt - bc0, 1);
      chk("s3_one_done", done_cnt - dc0, 1);

      // write, AW accepted before W
      aw_delay = 0; w_delay = 3; bc0 = b_cnt;
      drive_req(1'b1, 1'b0, 32'h208, 32'h12345678, 4'b1111);
      wait_done("s3b", 20, 6);
      chk("s3b_aw_w", {last_awaddr, last_wdata}, {32'h208, 32'h12345678});
      chk("s3b_one_b", b_cnt - bc0, 1);
      w_delay = 0;

      // rd and wr together: write wins
      drive_req(1'b1, 1'b1, 32'h20C, 32'hA5A5A5A5, 4'b1100);
      chk("s3c_prio", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b110);
      wait_done("s3c", 10, 3);
      chk("s3c_w", {last_awaddr, last_wdata, last_wstrb}, {32'h20C, 32'hA5A5A5A5, 4'b1100});

      // error responses
      rresp_cfg = 2'b10; rdata_cfg = 32'hBAD0BAD0;
      drive_req(1'b0, 1'b1, 32'h300, 32'h0, 4'h0);
      wait_done("s4_rerr", 10, 3);
      rresp_cfg = 2'b00; rdata_cfg = 32'h00000013;
      drive_req(1'b0, 1'b1, 32'h304, 32'h0, 4'h0);
      wait_done("s4_rok", 10, 3);
      bresp_cfg = 2'b11;
      drive_req(1'b1, 1'b0, 32'h308, 32'h55AA55AA, 4'b0001);
      wait_done("s4_berr", 10, 3);
      bresp_cfg = 2'b00;

      // continuous fetch, address advanced on each done
      rdata_by_addr = 1'b1;
      ar_log.delete();
      addr = 32'h0; rd = 1'b1; valid = 1'b1;
      model_dout = 32'hC0DE0000;
      e.dout = model_dout; e.err = 1'b0;
      sb.push_back(e);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (done !== 1'b1 && n < 12);
         chk($sformatf("s5_done%0d", k), done, 1'b1);
         e = sb.pop_front();
         chk($sformatf("s5_data%0d", k), data_out, e.dout);
         chk($sformatf("s5_interval%0d", k), n, (k == 0) ? 3 : 4);
         if (k < 3) begin
            addr = addr + 32'd4;
            model_dout = {16'hC0DE, addr[15:0]};
            e.dout = model_dout; e.err = 1'b0;
            sb.push_back(e);
         end else begin
            valid = 1'b0; rd = 1'b0;
         end
      end
      repeat (6) @(negedge clk);
      chk("s5_ar_count", ar_log.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("s5_araddr%0d", i), ar_log[i], 32'(4 * i));
      rdata_by_addr = 1'b0;

      // asynchronous reset while waiting for read data
      r_delay = 20; rdata_cfg = 32'hCAFEF00D;
      drive_req(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
      n = 0;
      while (bus.rready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("s6_in_rd_data", bus.rready, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("s6_async_rst", {bus.arvalid, bus.rready, done, busy}, 4'b0);
      chk("s6_dout_cleared", data_out, 32'h0);
      e = sb.pop_front();
      model_dout = '0;
      @(negedge clk);
      rst_n = 1'b1;
      r_delay = 0; rdata_cfg = 32'h0BADCAFE;
      @(negedge clk);
      drive_req(1'b0, 1'b1, 32'h404, 32'h0, 4'h0);
      wait_done("s6_fresh", 10, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
